// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks: digit width, add-3 threshold,
// converter FSM state type and the single-digit correction function.
package bcd_pkg;

  localparam int DIGIT_W     = 4;
  localparam int ADD3_THRESH = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Digits at or above the threshold would exceed 9 after the next doubling.
  function automatic bcd_digit_t add3_fix(input bcd_digit_t d);
    return (d >= bcd_digit_t'(ADD3_THRESH)) ? bcd_digit_t'(d + bcd_digit_t'(3)) : d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble correction cell for one BCD digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  assign digit_o = add3_fix(digit_i);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional overflow flag port enabled by defining BIN2BCD_OVF_EN.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out
`ifdef BIN2BCD_OVF_EN
  ,
  output logic                      ovf
`endif
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_fix;
  logic [SR_W-1:0]  sr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_q;
  logic             done_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_fix;

  // Independent per-digit correction; no carry ripples between digits.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_i (sr_q[WIDTH + g*DIGIT_W +: DIGIT_W]),
      .digit_o (bcd_fix[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign sr_fix = {bcd_fix, sr_q[WIDTH-1:0]};
  // The bit leaving the top digit is dropped by the truncating cast.
  assign sr_d   = SR_W'({sr_fix, 1'b0});
  assign cnt_d  = cnt_q - CNT_W'(1);

`ifdef BIN2BCD_OVF_EN
  logic shout_d;
  logic ovf_acc_q;
  logic ovf_q;

  assign shout_d = sr_fix[SR_W-1];
  assign ovf     = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
`ifdef BIN2BCD_OVF_EN
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q    <= SR_W'(bin_in);
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef BIN2BCD_OVF_EN
            ovf_acc_q <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_d;
`ifdef BIN2BCD_OVF_EN
          ovf_acc_q <= ovf_acc_q | shout_d;
`endif
          // Last shift: publish the whole BCD field at once.
          if (cnt_q == CNT_W'(1)) begin
            bcd_q   <= sr_d[SR_W-1 -: BCD_W];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef BIN2BCD_OVF_EN
            ovf_q <= ovf_acc_q | shout_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3); adds a
// DIGITS=2 overflow instance when BIN2BCD_OVF_EN is defined.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef BIN2BCD_OVF_EN
  logic       ovf;
  logic       start2;
  logic [7:0] bin2;
  logic       busy2;
  logic       done2;
  logic [7:0] bcd2;
  logic       ovf2;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
    .bin_in  (bin2),
    .busy    (busy2),
    .done    (done2),
    .bcd_out (bcd2),
    .ovf     (ovf2)
  );
`endif

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
`ifdef BIN2BCD_OVF_EN
    .ovf     (ovf),
`endif
    .bcd_out (bcd_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One conversion; checks latency, busy length, result and single-cycle done.
  task automatic run_conv(input string tag, input logic [7:0] val, input logic [11:0] exp);
    int n;
    int nbusy;
    bit seen;
    @(negedge clk);
    start  = 1'b1;
    bin_in = val;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'hA5;
    n = 1; nbusy = 0; seen = 0;
    while (n <= 40 && !seen) begin
      if (done) seen = 1;
      else begin
        if (busy) nbusy++;
        @(negedge clk);
        n++;
      end
    end
    if (!seen) chk({tag, " timeout"}, 32'd0, 32'd1);
    else begin
      chk({tag, " latency"}, n - 1, 8);
      chk({tag, " busy_cycles"}, nbusy, 8);
      chk({tag, " bcd"}, bcd_out, exp);
      chk({tag, " busy_at_done"}, busy, 0);
      @(negedge clk);
      chk({tag, " done_pulse"}, done, 0);
      chk({tag, " bcd_hold"}, bcd_out, exp);
    end
  endtask

  initial begin
    int n;
    int d1;
    int d2;
    int ndone;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 8'd0;
`ifdef BIN2BCD_OVF_EN
    start2 = 1'b0;
    bin2   = 8'd0;
`endif
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst bcd", bcd_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_conv("c255", 8'd255, 12'h255);
    run_conv("c0", 8'd0, 12'h000);
    run_conv("c99", 8'd99, 12'h099);

    // Start during SHIFT must be ignored.
    @(negedge clk);
    start = 1'b1; bin_in = 8'd128;
    @(negedge clk);
    start = 1'b0; bin_in = 8'd0;
    ndone = 0; d1 = 0;
    for (int i = 2; i <= 24; i++) begin
      if (i == 4) begin start = 1'b1; bin_in = 8'd7; end
      else if (i == 5) start = 1'b0;
      if (done) begin
        ndone++;
        if (d1 == 0) begin
          d1 = i;
          chk("ign bcd", bcd_out, 12'h128);
        end
      end
      @(negedge clk);
    end
    chk("ign done_count", ndone, 1);
    chk("ign bcd_final", bcd_out, 12'h128);

    // Reset mid-conversion aborts asynchronously.
    @(negedge clk);
    start = 1'b1; bin_in = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort bcd", bcd_out, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort no_done", ndone, 0);
    chk("abort bcd_after", bcd_out, 0);
    run_conv("c45", 8'd45, 12'h045);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; bin_in = 8'd37;
    @(negedge clk);
    bin_in = 8'd64;
    d1 = 0; d2 = 0;
    for (n = 1; n <= 30; n++) begin
      if (n == 10) start = 1'b0;
      if (done) begin
        if (d1 == 0) begin
          d1 = n;
          chk("b2b bcd1", bcd_out, 12'h037);
        end else if (d2 == 0) begin
          d2 = n;
          chk("b2b bcd2", bcd_out, 12'h064);
        end
      end
      @(negedge clk);
    end
    chk("b2b first_lat", d1, 9);
    chk("b2b spacing", d2 - d1, 9);
    chk("b2b idle", busy, 0);

`ifdef BIN2BCD_OVF_EN
    begin
      logic [7:0] vals [2];
      logic [7:0] exps [2];
      logic       ovfs [2];
      vals[0] = 8'd150; exps[0] = 8'h50; ovfs[0] = 1'b1;
      vals[1] = 8'd42;  exps[1] = 8'h42; ovfs[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        start2 = 1'b1; bin2 = vals[k];
        @(negedge clk);
        start2 = 1'b0;
        d1 = 0;
        for (int i = 1; i <= 20 && d1 == 0; i++) begin
          if (done2) d1 = i;
          else @(negedge clk);
        end
        chk("ovf latency", d1, 9);
        chk("ovf bcd", bcd2, exps[k]);
        chk("ovf flag", ovf2, ovfs[k]);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method; it is the inverse of the combinational BCD-to-binary decoder.
- Converts one WIDTH-bit unsigned value into DIGITS packed BCD digits, processing one bit per clock.
- Uses a start/busy/done handshake.
- Sits between binary counters and datapaths and the display/BCD consumers, e.g. 7-segment drivers.

Parameters:
- WIDTH, 8, bit width of the binary input (legal range 1..16).
- DIGITS, 3, number of BCD output digits (legal range 1..5). The default covers 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion of bin_in; sampled only in IDLE.
- bin_in  input  WIDTH  unsigned binary operand; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd_out is updated.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 (ones) is bits [3:0]; held until the next done.
- ovf  output  1  present only with BIN2BCD_OVF_EN (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, bcd_out=0, ovf=0, shift register and counter cleared.
- FSM states: IDLE, SHIFT.
  - IDLE + start=1 at edge k: shift register loads {4*DIGITS zeros, bin_in}, counter=WIDTH, next state SHIFT, busy=1 after edge k.
  - SHIFT, at each edge: every BCD digit >= 5 gets +3 (4-bit, no carry between digits), then the whole register shifts left by 1 and the counter decrements.
  - Exit from SHIFT: on the edge where the counter goes 1 -> 0, the register's BCD field goes to bcd_out, done=1 for exactly one cycle, busy=0, next state IDLE.
- Latency: start accepted at edge k -> done high in the cycle following edge k+WIDTH. Throughput is one conversion per WIDTH+1 cycles; a start asserted while done=1 is accepted, because the FSM is already IDLE.
- start while busy=1 is ignored; it is neither queued nor captured. bin_in changes during SHIFT have no effect.
- bcd_out changes only on the done edge or on reset. It is never partially updated.
- Reset mid-conversion aborts immediately: no done pulse, and bcd_out returns to 0.
- Width rule: if 10^DIGITS-1 < 2^WIDTH-1, bits shifted out of the top digit are discarded. The result is then the value modulo 10^DIGITS.
- bin_in=0 still takes WIDTH cycles and produces bcd_out=0.

Optional Feature:
- Macro: BIN2BCD_OVF_EN.
- Defined:
  - ovf port exists.
  - ovf is set if any 1 bit shifts out of the most-significant digit during the conversion.
  - ovf is updated together with bcd_out on the done edge, and holds until the next done or reset.
- Undefined: ovf port and its tracking logic are absent, and the overflow is silently truncated.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W=4.
  - ADD3_THRESH=5.
  - state typedef {IDLE, SHIFT}.
  - BCD digit typedef (4-bit).
- Sub-module bcd_add3:
  - combinational single-digit correction cell (in >= 5 ? in+3 : in);
  - instantiated DIGITS times in a generate loop.

Test Plan:
- WIDTH=8, DIGITS=3, bin_in=255, start pulse -> done exactly 8 cycles after the accepting edge, bcd_out=12'h255, busy high for those 8 cycles.
- bin_in=0, then bin_in=99 -> bcd_out=12'h000, then 12'h099; each done is a single-cycle pulse.
- start pulsed again 3 cycles into a conversion of 128, with bin_in=7 -> ignored; bcd_out=12'h128; no second done.
- rst asserted 4 cycles into a conversion of 200 -> busy, done and bcd_out go to 0 immediately (asynchronously); no done pulse follows; a subsequent conversion of 45 gives 12'h045.
- start held high, bin_in=37 then 64 -> back-to-back results 12'h037 and 12'h064, with done pulses 9 cycles apart.
- BIN2BCD_OVF_EN defined, DIGITS=2, bin_in=150 -> bcd_out=8'h50, ovf=1. Then bin_in=42 -> bcd_out=8'h42, ovf=0.
